// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access: byte enables, lane replication, load extract/extend, ALU pass-through.
// Latency: ALU result 1 cycle; memory op 1 cycle after request plus memory wait cycles (2 with zero-wait ack).
// Backpressure: stall holds EX/MEM from request issue until mem_ack; timeout aborts after TIMEOUT cycles.
module mem_access_stage #(
  parameter int TIMEOUT   = 200,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [1:0]           off_q, off_d;
  logic                 req_d, we_d, wbv_d, mis_d, err_d;
  logic [31:0]          addr_d, wdata_d, wbd_d;
  logic [3:0]           be_d;

  logic                 access, aligned;
  logic [3:0]           be_new;
  logic [31:0]          wdata_new, ld_word, byte_sh, half_sh;

  assign access = ex_valid & (ex_memread | ex_memwrite);

  always_comb begin
    case (ex_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ex_addr[0];
      default: aligned = (ex_addr[1:0] == 2'b00);
    endcase
  end

  // Loads always fetch the whole word; lanes are picked on the way back.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = ex_wdata;
    if (ex_memwrite) begin
      case (ex_size)
        2'b00: begin
          be_new    = 4'b0001 << ex_addr[1:0];
          wdata_new = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          be_new    = ex_addr[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{ex_wdata[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = ex_wdata;
        end
      endcase
    end
  end

  always_comb begin
    byte_sh = mem_rdata >> {off_q, 3'b000};
    half_sh = mem_rdata >> {off_q[1], 4'b0000};
    case (size_q)
      2'b00:   ld_word = uns_q ? {24'h0, byte_sh[7:0]}  : {{24{byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   ld_word = uns_q ? {16'h0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
      default: ld_word = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    be_d    = mem_be;
    wdata_d = mem_wdata;
    wbv_d   = 1'b0;
    wbd_d   = wb_data;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && aligned) begin
          req_d   = 1'b1;
          we_d    = ex_memwrite;
          addr_d  = {ex_addr[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          size_d  = ex_size;
          uns_d   = ex_unsigned;
          off_d   = ex_addr[1:0];
          cnt_d   = '0;
          state_d = ACCESS;
          stall   = 1'b1;
        end else if (access) begin
          mis_d = 1'b1;
        end else if (ex_valid) begin
          wbv_d = 1'b1;
          wbd_d = ex_result;
        end
      end
      ACCESS: begin
        stall = ~mem_ack;
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!mem_we) begin
            wbv_d = 1'b1;
            wbd_d = ld_word;
          end
        end else if (cnt_q == TIMEOUT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      wb_valid  <= 1'b0;
      wb_data   <= 32'h0;
      misalign  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_be    <= be_d;
      mem_wdata <= wdata_d;
      wb_valid  <= wbv_d;
      wb_data   <= wbd_d;
      misalign  <= mis_d;
      mem_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a transaction-level reference model checked every cycle.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ex_valid = 1'b0, ex_memread = 1'b0, ex_memwrite = 1'b0, ex_unsigned = 1'b0;
  logic [1:0]  ex_size = 2'b00;
  logic [31:0] ex_addr = '0, ex_wdata = '0, ex_result = '0;
  logic        mem_req, mem_we, stall, wb_valid, misalign, mem_err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mem_access_stage #(.TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .Reset(Reset),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_result(ex_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .misalign(misalign), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_aligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] rd, input logic [1:0] sz,
                                            input logic un, input int off);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * off)) % 256;
      if (!un && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (off / 2))) % 65536;
      if (!un && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  bit          m_busy = 0;
  int          m_waits = 0;
  logic [1:0]  m_size = 0;
  logic        m_uns = 0;
  int          m_off = 0;
  logic        e_req = 0, e_we = 0, e_wbv = 0, e_mis = 0, e_err = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_wbd = 0;
  logic [3:0]  e_be = 0;

  always @(posedge clk) begin
    if (Reset) begin
      m_busy <= 0; m_waits <= 0;
      e_req <= 0; e_we <= 0; e_addr <= 0; e_be <= 0; e_wdata <= 0;
      e_wbv <= 0; e_wbd <= 0; e_mis <= 0; e_err <= 0;
    end else begin
      e_wbv <= 0; e_mis <= 0; e_err <= 0;
      if (!m_busy) begin
        if (ex_valid && (ex_memread || ex_memwrite)) begin
          if (m_aligned(ex_size, ex_addr)) begin
            m_busy <= 1; m_waits <= 0;
            m_size <= ex_size; m_uns <= ex_unsigned; m_off <= int'(ex_addr % 4);
            e_req <= 1; e_we <= ex_memwrite; e_addr <= ex_addr - (ex_addr % 4);
            if (!ex_memwrite || ex_size >= 2) begin
              e_be <= 4'd15; e_wdata <= ex_wdata;
            end else if (ex_size == 0) begin
              e_be <= 4'(1 << (ex_addr % 4)); e_wdata <= (ex_wdata % 256) * 32'h0101_0101;
            end else begin
              e_be <= ((ex_addr % 4) >= 2) ? 4'd12 : 4'd3;
              e_wdata <= (ex_wdata % 65536) * 32'h0001_0001;
            end
          end else begin
            e_mis <= 1;
          end
        end else if (ex_valid) begin
          e_wbv <= 1; e_wbd <= ex_result;
        end
      end else if (mem_ack) begin
        m_busy <= 0; e_req <= 0;
        if (!e_we) begin
          e_wbv <= 1; e_wbd <= m_extract(mem_rdata, m_size, m_uns, m_off);
        end
      end else if (m_waits + 1 >= TO) begin
        m_busy <= 0; e_req <= 0; e_err <= 1;
      end else begin
        m_waits <= m_waits + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", mem_req, e_req);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_be", mem_be, e_be);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("wb_valid", wb_valid, e_wbv);
      chk("wb_data", wb_data, e_wbd);
      chk("misalign", misalign, e_mis);
      chk("mem_err", mem_err, e_err);
      chk("stall", stall, m_busy ? !mem_ack
                             : (ex_valid && (ex_memread || ex_memwrite) && m_aligned(ex_size, ex_addr)));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic mem_op(input logic we, input logic [1:0] sz, input logic un,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, output int nst, output logic [31:0] f_addr,
                        output logic [31:0] f_wdata, output logic [3:0] f_be, output logic f_we,
                        output logic f_req, output logic wbv, output logic [31:0] wbd);
    ex_valid = 1; ex_memread = !we; ex_memwrite = we; ex_size = sz; ex_unsigned = un;
    ex_addr = addr; ex_wdata = wd; mem_ack = 0;
    nst = 0;
    @(negedge clk); if (stall) nst++;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      @(negedge clk); if (stall) nst++;
    end
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = rd;
    @(negedge clk); if (stall) nst++;
    f_addr = mem_addr; f_wdata = mem_wdata; f_be = mem_be; f_we = mem_we; f_req = mem_req;
    @(posedge clk); #1;
    mem_ack = 0; mem_rdata = 32'h0; ex_valid = 0; ex_memread = 0; ex_memwrite = 0;
    @(negedge clk);
    wbv = wb_valid; wbd = wb_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nst, nreq;
    logic [31:0] fa, fw, wbd;
    logic [3:0] fb;
    logic fwe, freq, wbv, got_err;

    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    Reset = 0;
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_req", mem_req, 0);

    // 1: ALU pass-through
    @(posedge clk); #1;
    ex_valid = 1; ex_result = 32'h1234;
    @(negedge clk); chk("t1_stall", stall, 0);
    @(posedge clk); #1; ex_valid = 0;
    @(negedge clk);
    chk("t1_wb_valid", wb_valid, 1);
    chk("t1_wb_data", wb_data, 32'h1234);

    // 2: LB / LBU with 3 wait cycles
    @(posedge clk); #1;
    mem_op(0, 2'd0, 0, 32'h103, 0, 32'h80FF_0000, 3, nst, fa, fw, fb, fwe, freq, wbv, wbd);
    chk("lb_be", fb, 4'b1111);
    chk("lb_stall_cycles", nst, 4);
    chk("lb_wb_valid", wbv, 1);
    chk("lb_data", wbd, 32'hFFFF_FF80);
    @(posedge clk); #1;
    mem_op(0, 2'd0, 1, 32'h103, 0, 32'h80FF_0000, 3, nst, fa, fw, fb, fwe, freq, wbv, wbd);
    chk("lbu_data", wbd, 32'h0000_0080);

    // 3: SH zero-wait
    @(posedge clk); #1;
    mem_op(1, 2'd1, 0, 32'h202, 32'h0000_ABCD, 0, 0, nst, fa, fw, fb, fwe, freq, wbv, wbd);
    chk("sh_addr", fa, 32'h200);
    chk("sh_be", fb, 4'b1100);
    chk("sh_wdata", fw, 32'hABCD_ABCD);
    chk("sh_we", fwe, 1);
    chk("sh_req", freq, 1);
    chk("sh_no_wb", wbv, 0);
    chk("sh_stall_cycles", nst, 1);

    // extra lane patterns
    @(posedge clk); #1;
    mem_op(0, 2'd1, 0, 32'h302, 0, 32'h8001_7FFF, 1, nst, fa, fw, fb, fwe, freq, wbv, wbd);
    chk("lh_data", wbd, 32'hFFFF_8001);
    @(posedge clk); #1;
    mem_op(0, 2'd1, 1, 32'h302, 0, 32'h8001_7FFF, 0, nst, fa, fw, fb, fwe, freq, wbv, wbd);
    chk("lhu_data", wbd, 32'h0000_8001);
    @(posedge clk); #1;
    mem_op(0, 2'd2, 0, 32'h400, 0, 32'hDEAD_BEEF, 2, nst, fa, fw, fb, fwe, freq, wbv, wbd);
    chk("lw_data", wbd, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    mem_op(1, 2'd0, 0, 32'h501, 32'h1234_5677, 0, 0, nst, fa, fw, fb, fwe, freq, wbv, wbd);
    chk("sb_be", fb, 4'b0010);
    chk("sb_wdata", fw, 32'h7777_7777);
    @(posedge clk); #1;
    mem_op(1, 2'd3, 0, 32'h600, 32'hCAFE_F00D, 0, 1, nst, fa, fw, fb, fwe, freq, wbv, wbd);
    chk("sw_be", fb, 4'b1111);
    chk("sw_wdata", fw, 32'hCAFE_F00D);

    // 4: misaligned LW
    @(posedge clk); #1;
    ex_valid = 1; ex_memread = 1; ex_size = 2'd2; ex_addr = 32'h101;
    @(negedge clk); chk("mis_stall", stall, 0);
    @(posedge clk); #1; ex_valid = 0; ex_memread = 0;
    @(negedge clk);
    chk("mis_pulse", misalign, 1);
    chk("mis_req", mem_req, 0);
    chk("mis_wb_valid", wb_valid, 0);

    // 5: timeout
    @(posedge clk); #1;
    ex_valid = 1; ex_memread = 1; ex_size = 2'd2; ex_addr = 32'h700;
    nreq = 0; got_err = 0;
    for (int i = 0; i < 20 && !got_err; i++) begin
      @(negedge clk); if (mem_req) nreq++;
      @(posedge clk); #1;
      if (mem_err) begin
        got_err = 1; ex_valid = 0; ex_memread = 0;
      end
    end
    chk("to_err_seen", got_err, 1);
    chk("to_req_cycles", nreq, TO);
    @(negedge clk);
    chk("to_stall", stall, 0);
    chk("to_req_low", mem_req, 0);

    // 6: reset mid-access, then a late ack
    @(posedge clk); #1;
    ex_valid = 1; ex_memread = 1; ex_size = 2'd2; ex_addr = 32'h800;
    @(posedge clk); #1;
    @(posedge clk); #1;
    Reset = 1; ex_valid = 0; ex_memread = 0;
    @(posedge clk); #1;
    Reset = 0;
    @(negedge clk);
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_addr", mem_addr, 0);
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    chk("late_ack_wb", wb_valid, 0);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
